// File: rtl/puf_kernel_ctrl_hub.sv
// puf_kernel_ctrl_hub: host ap_ctrl handshake fanned out to NUM_CH PUF kernel channels.
// Latency: start edge -> ch_start next cycle; last required ch_done -> ap_done next cycle (min 2 from start).
// Backpressure: none on kernels; in chain mode ap_done is held until the host pulses ap_continue.
// Ports:
//   ap_clk, areset                 clock, async active-high reset
//   ap_start, ap_continue          host control (ap_continue used only when MODE_CHAIN=1)
//   ch_enable, timeout_cycles      per-run channel mask and watchdog limit (0 = off)
//   ch_done                        per-channel done pulses from the kernels
//   ch_start, ch_done_latched      masked launch pulse, sticky per-channel done
//   ap_idle, ap_done, ap_ready     host status
//   timeout_o, run_cycles          watchdog flag and saturating LAUNCH+RUN cycle count
module puf_kernel_ctrl_hub #(
  parameter int NUM_CH     = 4,
  parameter bit MODE_CHAIN = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              ap_start,
  input  logic              ap_continue,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_start,
  output logic [NUM_CH-1:0] ch_done_latched,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic                ap_start_r_q, ap_start_r_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   latched_q, latched_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;

  logic                start_edge;
  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_CH-1:0]   latched_upd;
  logic                complete;
  logic                wd_hit;

  always_comb begin
    state_d      = state_q;
    ap_start_r_d = ap_start;
    mask_d       = mask_q;
    latched_d    = latched_q;
    timeout_d    = timeout_q;
    run_cycles_d = run_cycles_q;

    start_edge  = ap_start & ~ap_start_r_q;
    // Saturate instead of wrapping so a stuck run never reads as a short one.
    cnt_inc     = (run_cycles_q == {CNT_W{1'b1}}) ? run_cycles_q : run_cycles_q + CNT_ONE;
    latched_upd = latched_q | (ch_done & mask_q);
    // A done pulse arriving in the same cycle counts toward completion.
    complete    = (((latched_q | ch_done) & mask_q) == mask_q);
    // The watchdog compares against the count including the current cycle, so
    // a run that times out reports run_cycles equal to the limit.
    wd_hit      = (timeout_cycles != '0) && (cnt_inc >= timeout_cycles);

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          mask_d       = ch_enable;
          latched_d    = '0;
          run_cycles_d = '0;
          timeout_d    = 1'b0;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        latched_d    = latched_upd;
        run_cycles_d = cnt_inc;
        state_d      = S_RUN;
      end
      S_RUN: begin
        latched_d    = latched_upd;
        run_cycles_d = cnt_inc;
        if (complete) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (!MODE_CHAIN || ap_continue) state_d = S_IDLE;
        else                            state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ap_continue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      ap_start_r_q <= 1'b0;
      mask_q       <= '0;
      latched_q    <= '0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      ap_start_r_q <= ap_start_r_d;
      mask_q       <= mask_d;
      latched_q    <= latched_d;
      timeout_q    <= timeout_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Host-facing status is decoded from the state register so that an async
  // reset drives every output to its idle value without a clock edge.
  assign ap_idle         = (state_q == S_IDLE);
  assign ap_done         = (state_q == S_DONE) || (state_q == S_HOLD);
  assign ap_ready        = (state_q == S_DONE);
  assign ch_start        = (state_q == S_LAUNCH) ? mask_q : '0;
  assign ch_done_latched = latched_q;
  assign timeout_o       = timeout_q;
  assign run_cycles      = run_cycles_q;

endmodule

// File: tb/tb_puf_kernel_ctrl_hub.sv
module tb_puf_kernel_ctrl_hub;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_continue = 1'b0;
  logic [3:0]  ch_enable = '0;
  logic [31:0] tmo = '0;
  logic [3:0]  sat_tmo = '0;
  logic [3:0]  ch_done = '0;

  logic [3:0]  hs_ch_start, hs_lat, ch_ch_start, ch_lat, sat_ch_start, sat_lat;
  logic        hs_idle, hs_done, hs_ready, hs_to;
  logic        ch_idle, ch_done_o, ch_ready, ch_to;
  logic        sat_idle, sat_done, sat_ready, sat_to;
  logic [31:0] hs_rc, ch_rc;
  logic [3:0]  sat_rc;

  always #5 clk = ~clk;

  puf_kernel_ctrl_hub #(.NUM_CH(4), .MODE_CHAIN(1'b0), .CNT_W(32)) dut_hs (
    .ap_clk(clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ch_enable(ch_enable), .timeout_cycles(tmo), .ch_done(ch_done),
    .ch_start(hs_ch_start), .ch_done_latched(hs_lat), .ap_idle(hs_idle),
    .ap_done(hs_done), .ap_ready(hs_ready), .timeout_o(hs_to), .run_cycles(hs_rc));

  puf_kernel_ctrl_hub #(.NUM_CH(4), .MODE_CHAIN(1'b1), .CNT_W(32)) dut_ch (
    .ap_clk(clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ch_enable(ch_enable), .timeout_cycles(tmo), .ch_done(ch_done),
    .ch_start(ch_ch_start), .ch_done_latched(ch_lat), .ap_idle(ch_idle),
    .ap_done(ch_done_o), .ap_ready(ch_ready), .timeout_o(ch_to), .run_cycles(ch_rc));

  puf_kernel_ctrl_hub #(.NUM_CH(4), .MODE_CHAIN(1'b0), .CNT_W(4)) dut_sat (
    .ap_clk(clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ch_enable(ch_enable), .timeout_cycles(sat_tmo), .ch_done(ch_done),
    .ch_start(sat_ch_start), .ch_done_latched(sat_lat), .ap_idle(sat_idle),
    .ap_done(sat_done), .ap_ready(sat_ready), .timeout_o(sat_to), .run_cycles(sat_rc));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One run record: mask, per-channel pulse cycle (relative to LAUNCH, 255 = never),
  // watchdog limit and the expected outcome.
  typedef struct {
    logic [3:0]      mask;
    logic [3:0][7:0] tt;
    logic [31:0]     tmo;
    int              done_k;
    logic [31:0]     rc;
    logic [3:0]      lat;
    logic            to;
  } vec_t;

  int          obs_done_k;
  logic [31:0] obs_rc;
  logic [3:0]  obs_lat;
  logic        obs_to, obs_ready, obs_cs_ok, obs_idle;

  task automatic do_reset();
    areset = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    ch_done = '0; ch_enable = '0; tmo = '0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
  endtask

  // Drive one run on the hs instance; k counts cycles from LAUNCH (k=0).
  task automatic do_run(input logic [3:0] mask, input logic [3:0][7:0] tt, input logic [31:0] limit);
    ch_enable = mask; tmo = limit; ap_start = 1'b1;
    @(negedge clk);
    obs_done_k = -1; obs_cs_ok = 1'b1; obs_rc = '0; obs_lat = '0; obs_to = 1'b0; obs_ready = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == 0) obs_cs_ok &= (hs_ch_start == mask) && !hs_idle;
      else        obs_cs_ok &= (hs_ch_start == 4'b0);
      if (hs_done) begin
        obs_done_k = k; obs_rc = hs_rc; obs_lat = hs_lat; obs_to = hs_to; obs_ready = hs_ready;
        break;
      end
      ap_start = 1'b0;
      for (int i = 0; i < 4; i++) ch_done[i] = (tt[i] == 8'(k));
      @(negedge clk);
    end
    ch_done = '0;
    @(negedge clk);
    obs_idle = hs_idle && !hs_done;
  endtask

  task automatic check_run(input string tag, input int done_k, input logic [31:0] rc,
                           input logic [3:0] lat, input logic to);
    chk({tag, ".done_k"}, 64'(obs_done_k), 64'(done_k));
    chk({tag, ".run_cycles"}, 64'(obs_rc), 64'(rc));
    chk({tag, ".latched"}, 64'(obs_lat), 64'(lat));
    chk({tag, ".timeout_o"}, 64'(obs_to), 64'(to));
    chk({tag, ".ap_ready"}, 64'(obs_ready), 64'(1));
    chk({tag, ".ch_start"}, 64'(obs_cs_ok), 64'(1));
    chk({tag, ".idle_after"}, 64'(obs_idle), 64'(1));
  endtask

  // Outcome model from the run rules: find the cycle in which every masked channel
  // has pulsed (never before the first RUN cycle), and the last cycle the watchdog
  // allows; whichever comes first (completion on a tie) ends the run.
  task automatic model(input logic [3:0] mask, input logic [3:0][7:0] tt, input logic [31:0] limit,
                       output int done_k, output logic [31:0] rc, output logic [3:0] lat, output logic to);
    int last = 1;
    int tl;
    bit all_done = 1'b1;
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        if (tt[i] == 8'd255) all_done = 1'b0;
        else if (int'(tt[i]) > last) last = int'(tt[i]);
      end
    tl = (limit == 0) ? 1000000 : ((int'(limit) - 1 > 1) ? int'(limit) - 1 : 1);
    lat = '0;
    if (all_done && last <= tl) begin
      done_k = last + 1; to = 1'b0; lat = mask;
    end else begin
      done_k = tl + 1; to = 1'b1;
      for (int i = 0; i < 4; i++) lat[i] = mask[i] && (tt[i] != 8'd255) && (int'(tt[i]) <= tl);
    end
    rc = 32'(done_k);
  endtask

  vec_t vecs[8];

  initial begin
    int          e_k;
    logic [31:0] e_rc;
    logic [3:0]  e_lat;
    logic        e_to;
    logic [3:0]  m;
    logic [3:0][7:0] tt;
    logic [31:0] lim;
    bit          never;
    int          cs_cnt, done_cnt, ready_cnt, idle_bad;
    logic        idle11, idle12;

    vecs[0] = '{4'b1011, {8'd9,   8'd6,   8'd12,  8'd5},   32'd0,  13, 32'd13, 4'b1011, 1'b0};
    vecs[1] = '{4'b1011, {8'd9,   8'd255, 8'd255, 8'd5},   32'd20, 20, 32'd20, 4'b1001, 1'b1};
    vecs[2] = '{4'b1011, {8'd9,   8'd255, 8'd19,  8'd5},   32'd20, 20, 32'd20, 4'b1011, 1'b0};
    vecs[3] = '{4'b0000, {8'd3,   8'd3,   8'd3,   8'd3},   32'd0,  2,  32'd2,  4'b0000, 1'b0};
    vecs[4] = '{4'b0001, {8'd255, 8'd255, 8'd255, 8'd0},   32'd0,  2,  32'd2,  4'b0001, 1'b0};
    vecs[5] = '{4'b0100, {8'd255, 8'd3,   8'd255, 8'd1},   32'd0,  4,  32'd4,  4'b0100, 1'b0};
    vecs[6] = '{4'b0001, {8'd255, 8'd255, 8'd255, 8'd255}, 32'd1,  2,  32'd2,  4'b0000, 1'b1};
    vecs[7] = '{4'b1111, {8'd4,   8'd4,   8'd4,   8'd4},   32'd4,  4,  32'd4,  4'b0000, 1'b1};

    do_reset();
    chk("rst.ap_idle", 64'(hs_idle), 64'(1));
    chk("rst.ap_done", 64'(hs_done), 64'(0));
    chk("rst.ap_ready", 64'(hs_ready), 64'(0));
    chk("rst.ch_start", 64'(hs_ch_start), 64'(0));
    chk("rst.latched", 64'(hs_lat), 64'(0));
    chk("rst.timeout_o", 64'(hs_to), 64'(0));
    chk("rst.run_cycles", 64'(hs_rc), 64'(0));

    foreach (vecs[v]) begin
      do_run(vecs[v].mask, vecs[v].tt, vecs[v].tmo);
      check_run($sformatf("vec%0d", v), vecs[v].done_k, vecs[v].rc, vecs[v].lat, vecs[v].to);
    end

    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom_range(0, 15));
      never = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          tt[i] = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom_range(0, 30));
          if (tt[i] == 8'd255) never = 1'b1;
        end else begin
          tt[i] = 8'($urandom_range(0, 40));
        end
      end
      if (never) lim = 32'($urandom_range(1, 30));
      else       lim = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 35));
      model(m, tt, lim, e_k, e_rc, e_lat, e_to);
      do_run(m, tt, lim);
      check_run($sformatf("rnd%0d", r), e_k, e_rc, e_lat, e_to);
    end

    // Saturation: 20 LAUNCH+RUN cycles on a 4-bit counter.
    do_reset();
    do_run(4'b0001, {8'd255, 8'd255, 8'd255, 8'd19}, 32'd0);
    chk("sat.hs_run_cycles", 64'(obs_rc), 64'(20));
    chk("sat.run_cycles", 64'(sat_rc), 64'(15));
    chk("sat.idle", 64'(sat_idle), 64'(1));

    // Chain mode: done at k=3, ap_continue low through k=9, high at k=10.
    do_reset();
    ch_enable = 4'b0001; ap_start = 1'b1;
    @(negedge clk);
    chk("chain.ch_start", 64'(ch_ch_start), 64'(1));
    cs_cnt = 0; done_cnt = 0; ready_cnt = 0; idle_bad = 0; idle11 = 1'b0; idle12 = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k >= 1 && ch_ch_start != 4'b0) cs_cnt++;
      if (ch_done_o) done_cnt++;
      if (ch_ready) ready_cnt++;
      if (k <= 10 && ch_idle) idle_bad++;
      if (k == 11) idle11 = ch_idle;
      if (k == 12) idle12 = ch_idle;
      ap_start    = (k >= 5);
      ch_done     = (k == 2) ? 4'b0001 : 4'b0000;
      ap_continue = (k == 10);
      @(negedge clk);
    end
    chk("chain.done_cycles", 64'(done_cnt), 64'(8));
    chk("chain.ready_cycles", 64'(ready_cnt), 64'(1));
    chk("chain.idle_low", 64'(idle_bad), 64'(0));
    chk("chain.idle_after", 64'(idle11), 64'(1));
    chk("chain.no_restart", 64'(cs_cnt), 64'(0));
    chk("chain.still_idle", 64'(idle12), 64'(1));
    chk("chain.latched", 64'(ch_lat), 64'(1));

    // Async reset mid-run with ap_start held high.
    do_reset();
    ch_enable = 4'b1111; ap_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ch_done = (k == 1) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    ch_done = '0;
    chk("arst.pre_latched", 64'(hs_lat), 64'(1));
    chk("arst.pre_run_cycles", 64'(hs_rc), 64'(3));
    #2 areset = 1'b1;
    #1;
    chk("arst.ap_idle", 64'(hs_idle), 64'(1));
    chk("arst.ap_done", 64'(hs_done), 64'(0));
    chk("arst.latched", 64'(hs_lat), 64'(0));
    chk("arst.run_cycles", 64'(hs_rc), 64'(0));
    chk("arst.timeout_o", 64'(hs_to), 64'(0));
    @(negedge clk);
    areset = 1'b0;
    cs_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (hs_ch_start != 4'b0) cs_cnt++;
    end
    chk("arst.one_launch", 64'(cs_cnt), 64'(1));
    ap_start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
